if_fetch_unit: RTL and testbench

- Instruction-fetch front end of the ARM 5-stage pipeline.
- Owns the PC and issues single-outstanding requests to the instruction memory over a req/rvalid handshake.
- Buffers returned words and presents {pc+4, instruction} to the IF/ID pipeline register, which samples them on every posedge where freeze=0.
- Honours freeze (hazard stall) and branch redirect from EXE. Drives NOP bubbles whenever no fetched word is available.

---
 rtl/arm_pipe_pkg.sv | 15 +
 rtl/if_skid_buffer.sv | 36 +++
 rtl/if_fetch_unit.sv | 136 +++++++++++++
 tb/tb_if_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared constants and types for the ARM 5-stage pipeline front end.
package arm_pipe_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'hE000_0000;

  typedef enum logic [1:0] {FETCH, WAIT_SLOT, DISCARD} fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetched {pc, instr} pair.
// Priority: clear over load over pop.
module if_skid_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        pop,
  input  logic        clear,
  input  logic [31:0] din_pc,
  input  logic [31:0] din_instr,
  output logic [31:0] dout_pc,
  output logic [31:0] dout_instr,
  output logic        valid
);
  import arm_pipe_pkg::*;

  if_entry_t entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= '{pc: din_pc, instr: din_instr};
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  assign dout_pc    = entry.pc;
  assign dout_instr = entry.instr;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding imem requests
// and feeds the IF/ID register. Optional counters: define IF_PERF_CNT_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = arm_pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = arm_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        fetch_stall
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] redirect_cnt
`endif
);
  import arm_pipe_pkg::*;

  fetch_state_t      state;
  logic              started;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] discard_addr;
  logic              out_valid;
  if_entry_t         out_entry;
  if_entry_t         rsp_entry;
  logic              skid_valid;
  logic [WORD_W-1:0] skid_pc;
  logic [WORD_W-1:0] skid_instr;
  logic              accept;
  logic              skid_load;
  logic              skid_pop;

  // started keeps the request low for the first cycle out of reset, so a stale
  // response from before reset is never taken.
  assign imem_req  = started && (state != WAIT_SLOT);
  assign imem_addr = (state == DISCARD) ? discard_addr : pc;

  assign accept    = imem_req && imem_rvalid && (state == FETCH) && !branch_taken;
  assign rsp_entry = '{pc: pc, instr: imem_rdata};
  assign skid_load = accept && out_valid && freeze;
  assign skid_pop  = !freeze && skid_valid && !branch_taken;

  if_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .pop       (skid_pop),
    .clear     (branch_taken),
    .din_pc    (pc),
    .din_instr (imem_rdata),
    .dout_pc   (skid_pc),
    .dout_instr(skid_instr),
    .valid     (skid_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      started      <= 1'b0;
      pc           <= RESET_PC;
      discard_addr <= RESET_PC;
      out_valid    <= 1'b0;
      out_entry    <= '0;
    end else begin
      started <= 1'b1;
      if (branch_taken) begin
        pc        <= branch_addr;
        out_valid <= 1'b0;
        case (state)
          FETCH: begin
            if (imem_req && !imem_rvalid) begin
              state        <= DISCARD;
              discard_addr <= pc;
            end
          end
          DISCARD: state <= imem_rvalid ? FETCH : DISCARD;
          default: state <= FETCH;
        endcase
      end else begin
        if (accept) begin
          pc <= pc + 32'd4;
        end
        // Output register: skid first, then this cycle's response, else a bubble.
        if (!freeze) begin
          if (skid_valid) begin
            out_valid <= 1'b1;
            out_entry <= '{pc: skid_pc, instr: skid_instr};
          end else if (accept) begin
            out_valid <= 1'b1;
            out_entry <= rsp_entry;
          end else begin
            out_valid <= 1'b0;
          end
        end else if (!out_valid && accept) begin
          out_valid <= 1'b1;
          out_entry <= rsp_entry;
        end
        case (state)
          FETCH:     if (skid_load) state <= WAIT_SLOT;
          WAIT_SLOT: if (!freeze) state <= FETCH;
          DISCARD:   if (imem_req && imem_rvalid) state <= FETCH;
          default:   state <= FETCH;
        endcase
      end
    end
  end

  assign pc_out          = out_valid ? out_entry.pc + 32'd4 : '0;
  assign instruction_out = out_valid ? out_entry.instr : NOP_INSTR;
  assign fetch_stall     = !out_valid;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt   <= '0;
      redirect_cnt <= '0;
    end else begin
      if (!freeze && !out_valid && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if (branch_taken && (redirect_cnt != 32'hFFFF_FFFF)) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, hand sequences for
// redirect/wrap corners, then randomized traffic against a program-order model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        fetch_stall;
`ifdef IF_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] redirect_cnt;
`endif

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'hE000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc_out         (pc_out),
    .instruction_out(instruction_out),
    .fetch_stall    (fetch_stall)
`ifdef IF_PERF_CNT_EN
    ,
    .bubble_cnt     (bubble_cnt),
    .redirect_cnt   (redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        f;
    logic        b;
    logic [31:0] ba;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        stall;
  } vec_t;

  vec_t vecs[22];

  int total = 0;
  int bad   = 0;

  // Memory responder state and per-cycle samples of the DUT outputs
  logic        mem_pend;
  int          mem_cnt;
  int          mem_lat;
  logic        mem_rand;
  logic [31:0] mem_addr;
  logic        s_req;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_instr;
  logic        s_stall;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic f, input logic b, input logic [31:0] ba,
                              input logic req, input logic [31:0] addr,
                              input logic [31:0] pc, input logic stall);
    vec_t v;
    v.f = f; v.b = b; v.ba = ba; v.req = req; v.addr = addr; v.pc = pc; v.stall = stall;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One cycle: sample outputs at the negedge, run the memory, then drive inputs.
  task automatic applyStimulus(input logic f, input logic b, input logic [31:0] ba);
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_pc    = pc_out;
    s_instr = instruction_out;
    s_stall = fetch_stall;
    if (mem_pend && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(mem_addr);
      mem_pend    = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (mem_pend) mem_cnt--;
    end
    if (!mem_pend && !imem_rvalid && s_req) begin
      mem_pend = 1'b1;
      mem_addr = s_addr;
      mem_cnt  = (mem_rand ? $urandom_range(1, 4) : mem_lat) - 1;
    end
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
  endtask

  // Reset with a stale response driven during the release cycle; it must be ignored.
  task automatic doReset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; mem_pend = 1'b0; mem_cnt = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_pc_out", pc_out, 32'd0);
    checkOutput("rst_instr", instruction_out, NOP);
    checkOutput("rst_stall", {31'b0, fetch_stall}, 32'd1);
`ifdef IF_PERF_CNT_EN
    checkOutput("rst_bubble_cnt", bubble_cnt, 32'd0);
    checkOutput("rst_redirect_cnt", redirect_cnt, 32'd0);
`endif
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        found;
    logic        f, b;
    logic [31:0] ba, exp_pc, prev_addr;
    logic        prev_req, prev_rvalid;
    int          idle, consumed, exp_bub, exp_red;

    rst = 1'b1;
    mem_lat = 1; mem_rand = 1'b0; mem_addr = 32'h0;

    //        f  b  ba          req addr          pc_out        stall
    vecs[0]  = mk(0, 0, 32'h0,   1, 32'h0000_0000, 32'h0000_0000, 1);
    vecs[1]  = mk(0, 0, 32'h0,   1, 32'h0000_0000, 32'h0000_0000, 1);
    vecs[2]  = mk(0, 0, 32'h0,   1, 32'h0000_0004, 32'h0000_0004, 0);
    vecs[3]  = mk(0, 0, 32'h0,   1, 32'h0000_0004, 32'h0000_0000, 1);
    vecs[4]  = mk(0, 0, 32'h0,   1, 32'h0000_0008, 32'h0000_0008, 0);
    vecs[5]  = mk(0, 0, 32'h0,   1, 32'h0000_0008, 32'h0000_0000, 1);
    vecs[6]  = mk(0, 0, 32'h0,   1, 32'h0000_000C, 32'h0000_000C, 0);
    vecs[7]  = mk(0, 0, 32'h0,   1, 32'h0000_000C, 32'h0000_0000, 1);
    vecs[8]  = mk(0, 0, 32'h0,   1, 32'h0000_0010, 32'h0000_0010, 0);
    vecs[9]  = mk(0, 0, 32'h0,   1, 32'h0000_0010, 32'h0000_0000, 1);
    vecs[10] = mk(1, 0, 32'h0,   1, 32'h0000_0014, 32'h0000_0014, 0);
    vecs[11] = mk(1, 0, 32'h0,   1, 32'h0000_0014, 32'h0000_0014, 0);
    vecs[12] = mk(1, 0, 32'h0,   0, 32'h0000_0018, 32'h0000_0014, 0);
    vecs[13] = mk(1, 0, 32'h0,   0, 32'h0000_0018, 32'h0000_0014, 0);
    vecs[14] = mk(0, 0, 32'h0,   0, 32'h0000_0018, 32'h0000_0014, 0);
    vecs[15] = mk(0, 0, 32'h0,   1, 32'h0000_0018, 32'h0000_0018, 0);
    vecs[16] = mk(0, 0, 32'h0,   1, 32'h0000_0018, 32'h0000_0000, 1);
    vecs[17] = mk(1, 0, 32'h0,   1, 32'h0000_001C, 32'h0000_001C, 0);
    vecs[18] = mk(1, 1, 32'h200, 1, 32'h0000_001C, 32'h0000_001C, 0);
    vecs[19] = mk(1, 0, 32'h0,   1, 32'h0000_0200, 32'h0000_0000, 1);
    vecs[20] = mk(1, 0, 32'h0,   1, 32'h0000_0200, 32'h0000_0000, 1);
    vecs[21] = mk(0, 0, 32'h0,   1, 32'h0000_0204, 32'h0000_0204, 0);

    // Directed table: zero-wait stream, freeze with skid fill, branch+rvalid under freeze
    doReset();
    exp_bub = 1;
    exp_red = 0;
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].f, vecs[i].b, vecs[i].ba);
      checkOutput($sformatf("vec%0d_req", i), {31'b0, s_req}, {31'b0, vecs[i].req});
      checkOutput($sformatf("vec%0d_addr", i), s_addr, vecs[i].addr);
      checkOutput($sformatf("vec%0d_pc_out", i), s_pc, vecs[i].pc);
      checkOutput($sformatf("vec%0d_stall", i), {31'b0, s_stall}, {31'b0, vecs[i].stall});
      checkOutput($sformatf("vec%0d_instr", i), s_instr,
                  vecs[i].stall ? NOP : word(vecs[i].pc - 32'd4));
`ifdef IF_PERF_CNT_EN
      checkOutput($sformatf("vec%0d_bubble_cnt", i), bubble_cnt, exp_bub);
      checkOutput($sformatf("vec%0d_redirect_cnt", i), redirect_cnt, exp_red);
`endif
      if (!vecs[i].f && vecs[i].stall) exp_bub++;
      if (vecs[i].b) exp_red++;
    end

    // Redirect while the request to 0x20 is outstanding (3-cycle memory)
    doReset();
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (s_req && s_addr == 32'h20) found = 1'b1;
    end
    checkOutput("t4_reach_0x20", {31'b0, found}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h100);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("t4_hold_req%0d", k), {31'b0, s_req}, 32'd1);
      checkOutput($sformatf("t4_hold_addr%0d", k), s_addr, 32'h20);
      checkOutput($sformatf("t4_hold_stall%0d", k), {31'b0, s_stall}, 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("t4_new_addr%0d", k), s_addr, 32'h100);
      checkOutput($sformatf("t4_new_stall%0d", k), {31'b0, s_stall}, 32'd1);
    end
    mem_lat = 1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t4_first_pc_out", s_pc, 32'h104);
    checkOutput("t4_first_instr", s_instr, word(32'h100));

    // Branch to the top of memory together with a response; fetch must wrap to 0
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t6_addr", s_addr, 32'hFFFF_FFFC);
    checkOutput("t6_dropped_instr", s_instr, NOP);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t6_wrap_pc_out", s_pc, 32'h0);
    checkOutput("t6_wrap_stall", {31'b0, s_stall}, 32'd0);
    checkOutput("t6_wrap_instr", s_instr, word(32'hFFFF_FFFC));
    checkOutput("t6_wrap_addr", s_addr, 32'h0);

    // Randomized traffic: every consumed word must follow program order
    doReset();
    mem_rand = 1'b1;
    exp_pc = 32'h0; idle = 0; consumed = 0;
    prev_req = 1'b0; prev_rvalid = 1'b0; prev_addr = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      f  = ($urandom_range(0, 9) < 3);
      b  = ($urandom_range(0, 29) == 0);
      ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
      applyStimulus(f, b, ba);
      if (s_stall) begin
        checkOutput("rnd_bubble_pc", s_pc, 32'h0);
        checkOutput("rnd_bubble_instr", s_instr, NOP);
      end
      if (b) begin
        exp_pc = ba;
        idle = 0;
      end else if (!s_stall && !f) begin
        checkOutput("rnd_pc_out", s_pc, exp_pc + 32'd4);
        checkOutput("rnd_instr", s_instr, word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
        idle = 0;
      end else if (s_stall && !f) begin
        idle++;
      end
      if (prev_req && !prev_rvalid) begin
        checkOutput("rnd_req_hold", {31'b0, s_req}, 32'd1);
        checkOutput("rnd_addr_hold", s_addr, prev_addr);
      end
      if (idle > 24) begin
        total++;
        bad++;
        $display("[TB] FAIL rnd_progress: got %0d idle cycles expected at most 24", idle);
        idle = 0;
      end
      prev_req    = s_req;
      prev_rvalid = imem_rvalid;
      prev_addr   = s_addr;
    end
    checkOutput("rnd_consumed", {31'b0, consumed > 200}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
